// File: rtl/axi_sim_ram_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4 simulation RAM.
package axi_sim_ram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic {
        WR_IDLE,
        WR_BURST
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

    // Transfers wider than the bus are treated as full-width beats.
    function automatic logic [2:0] clamp_size(input logic [2:0] size,
                                              input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/axi_r_pipe_reg.sv
// Valid/ready skid buffer: registered outputs, full throughput, one cycle latency.
module axi_r_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // Route incoming beats to the output register, or park one in the skid slot.
    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (s_ready_q) begin
            if (s_valid) begin
                if (!m_valid_q || m_ready) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = s_data;
                end
            end else if (m_ready) begin
                m_valid_d = 1'b0;
            end
        end else if (m_ready) begin
            m_valid_d    = 1'b1;
            m_data_d     = skid_data_q;
            skid_valid_d = 1'b0;
        end
        s_ready_d = !skid_valid_d;
    end

    // Slice state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: rtl/axi_sim_ram.sv
// AXI4 slave RAM model with independent read and write burst engines.
module axi_sim_ram
    import axi_sim_ram_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int         STRB_LOG         = $clog2(STRB_WIDTH);
    localparam int         VALID_ADDR_WIDTH = ADDR_WIDTH - STRB_LOG;
    localparam int         MEM_DEPTH        = 1 << VALID_ADDR_WIDTH;
    localparam logic [2:0] MAX_SIZE         = 3'(STRB_LOG);

    // Advance a beat address; FIXED bursts stay put, everything else increments.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0]            size,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] step;
        step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << clamp_size(size, MAX_SIZE);
        return (burst == BURST_FIXED) ? addr : addr + step;
    endfunction

    // Lock/cache/prot carry no meaning for a plain memory; wlast is redundant with awlen.
    wire unused_inputs = &{1'b0, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_wlast};

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1] = '{default: '0};

    // ---------------- write engine ----------------
    wr_state_t             wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_cnt_q, wr_cnt_d;
    logic [2:0]            wr_size_q, wr_size_d;
    logic [1:0]            wr_burst_q, wr_burst_d;
    logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;

    logic                        wr_fire;
    logic [STRB_WIDTH-1:0]       wr_be;
    logic [VALID_ADDR_WIDTH-1:0] wr_word;

    assign wr_fire = wready_q && s_axi_wvalid;
    assign wr_word = wr_addr_q[ADDR_WIDTH-1:STRB_LOG];

    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_be
        assign wr_be[gi] = wr_fire && s_axi_wstrb[gi];
    end

    // Write FSM: accept AW, absorb awlen+1 beats, then post one B response.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_cnt_d   = wr_cnt_q;
        wr_size_d  = wr_size_q;
        wr_burst_d = wr_burst_q;
        wr_id_d    = wr_id_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        case (wr_state_q)
            WR_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    wr_addr_d  = s_axi_awaddr;
                    wr_cnt_d   = s_axi_awlen;
                    wr_size_d  = s_axi_awsize;
                    wr_burst_d = s_axi_awburst;
                    wr_id_d    = s_axi_awid;
                    wready_d   = 1'b1;
                    wr_state_d = WR_BURST;
                end
            end
            WR_BURST: begin
                if (wr_fire) begin
                    wr_addr_d = next_addr(wr_addr_q, wr_size_q, wr_burst_q);
                    wr_cnt_d  = wr_cnt_q - 8'd1;
                    if (wr_cnt_q == 8'd0) begin
                        wready_d   = 1'b0;
                        bvalid_d   = 1'b1;
                        bid_d      = wr_id_q;
                        wr_state_d = WR_IDLE;
                    end
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        // A pending response blocks the next address until it is taken.
        awready_d = (wr_state_d == WR_IDLE) && !bvalid_d;
    end

    // Write engine registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WR_IDLE;
            wr_addr_q  <= '0;
            wr_cnt_q   <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= '0;
            wr_id_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_size_q  <= wr_size_d;
            wr_burst_q <= wr_burst_d;
            wr_id_q    <= wr_id_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
        end
    end

    // Byte-masked memory write; the array itself is never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wr_be[b]) begin
                mem[wr_word][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = RESP_OKAY;

    // ---------------- read engine ----------------
    rd_state_t             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]            rd_cnt_q, rd_cnt_d;
    logic [2:0]            rd_size_q, rd_size_d;
    logic [1:0]            rd_burst_q, rd_burst_d;
    logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                        rd_ready_int;
    logic                        rd_take;
    logic                        rd_issue;
    logic [ADDR_WIDTH-1:0]       rd_src_addr;
    logic [7:0]                  rd_src_cnt;
    logic [2:0]                  rd_src_size;
    logic [1:0]                  rd_src_burst;
    logic [ID_WIDTH-1:0]         rd_src_id;
    logic [VALID_ADDR_WIDTH-1:0] rd_word;

    assign rd_take = (rd_state_q == RD_IDLE) && arready_q && s_axi_arvalid;

    // Beat source: the AR channel directly on acceptance, latched fields mid-burst.
    // Issuing the first beat off the AR handshake keeps rvalid one cycle behind AR.
    always_comb begin
        if (rd_state_q == RD_BURST) begin
            rd_src_addr  = rd_addr_q;
            rd_src_cnt   = rd_cnt_q;
            rd_src_size  = rd_size_q;
            rd_src_burst = rd_burst_q;
            rd_src_id    = rd_id_q;
        end else begin
            rd_src_addr  = s_axi_araddr;
            rd_src_cnt   = s_axi_arlen;
            rd_src_size  = s_axi_arsize;
            rd_src_burst = s_axi_arburst;
            rd_src_id    = s_axi_arid;
        end
        rd_issue = ((rd_state_q == RD_BURST) || rd_take) && (!rvalid_q || rd_ready_int);
        rd_word  = rd_src_addr[ADDR_WIDTH-1:STRB_LOG];
    end

    // Read FSM: issue one beat whenever the output slot is free.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        rd_size_d  = rd_size_q;
        rd_burst_d = rd_burst_q;
        rd_id_d    = rd_id_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rid_d      = rid_q;
        if (rvalid_q && rd_ready_int) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
        if (rd_issue) begin
            rvalid_d   = 1'b1;
            rid_d      = rd_src_id;
            rlast_d    = (rd_src_cnt == 8'd0);
            rd_addr_d  = next_addr(rd_src_addr, rd_src_size, rd_src_burst);
            rd_cnt_d   = rd_src_cnt - 8'd1;
            rd_size_d  = rd_src_size;
            rd_burst_d = rd_src_burst;
            rd_id_d    = rd_src_id;
            if (rd_src_cnt == 8'd0) begin
                rd_state_d = RD_IDLE;
                arready_d  = 1'b1;
            end else begin
                rd_state_d = RD_BURST;
                arready_d  = 1'b0;
            end
        end else if (rd_take) begin
            rd_addr_d  = rd_src_addr;
            rd_cnt_d   = rd_src_cnt;
            rd_size_d  = rd_src_size;
            rd_burst_d = rd_src_burst;
            rd_id_d    = rd_src_id;
            rd_state_d = RD_BURST;
            arready_d  = 1'b0;
        end else if (rd_state_q == RD_IDLE) begin
            arready_d = 1'b1;
        end
    end

    // Read engine registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
            rd_id_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_size_q  <= rd_size_d;
            rd_burst_q <= rd_burst_d;
            rd_id_q    <= rd_id_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
        end
    end

    // Registered memory read; same-cycle write to this word yields the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_issue) begin
            rdata_q <= mem[rd_word];
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rresp   = RESP_OKAY;

    if (PIPELINE_OUTPUT != 0) begin : g_pipe
        logic [ID_WIDTH+DATA_WIDTH:0] pipe_out;

        axi_r_pipe_reg #(
            .WIDTH(ID_WIDTH + DATA_WIDTH + 1)
        ) u_r_pipe (
            .clk    (clk),
            .rst    (rst),
            .s_valid(rvalid_q),
            .s_ready(rd_ready_int),
            .s_data ({rid_q, rdata_q, rlast_q}),
            .m_valid(s_axi_rvalid),
            .m_ready(s_axi_rready),
            .m_data (pipe_out)
        );

        assign s_axi_rid   = pipe_out[ID_WIDTH+DATA_WIDTH:DATA_WIDTH+1];
        assign s_axi_rdata = pipe_out[DATA_WIDTH:1];
        assign s_axi_rlast = pipe_out[0];
    end else begin : g_direct
        assign rd_ready_int = s_axi_rready;
        assign s_axi_rvalid = rvalid_q;
        assign s_axi_rid    = rid_q;
        assign s_axi_rdata  = rdata_q;
        assign s_axi_rlast  = rlast_q;
    end

endmodule

// File: tb/tb_axi_sim_ram.sv
// Directed bench for axi_sim_ram: bursts, FIXED mode, backpressure, reset mid-burst.
module tb_axi_sim_ram;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int IW = 8;
    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [0:0]    wstrb = 1'b1;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b1;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_sim_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .PIPELINE_OUTPUT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [15:0] addr, input logic [7:0] len,
                            input logic [7:0] id, input logic [1:0] burst,
                            input logic [7:0] base);
        awaddr = addr; awlen = len; awid = id; awburst = burst; awsize = 3'd0;
        awvalid = 1'b1;
        for (int k = 0; k < 20 && !awready; k++) step();
        check("aw_ready", awready, 1);
        step();
        awvalid = 1'b0;
        check("w_ready_first", wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = 8'(int'(base) + i);
            wlast  = (i == int'(len));
            step();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("b_valid", bvalid, 1);
        check("b_id", bid, id);
        check("b_resp", bresp, 0);
        check("w_ready_done", wready, 0);
        $display("WRITE addr=0x%04h len=%0d id=%0d burst=%0d base=%0d", addr, len, id, burst, base);
        if (bready) begin
            step();
            check("b_taken", bvalid, 0);
        end
    endtask

    task automatic rd_burst(input logic [15:0] addr, input logic [7:0] len,
                            input logic [7:0] id, input logic [1:0] burst,
                            input logic [7:0] exp_base, input logic [7:0] exp_step,
                            input int stall);
        araddr = addr; arlen = len; arid = id; arburst = burst; arsize = 3'd0;
        arvalid = 1'b1;
        rready  = (stall == 0);
        for (int k = 0; k < 20 && !arready; k++) step();
        check("ar_ready", arready, 1);
        step();
        arvalid = 1'b0;
        check("r_valid_first", rvalid, 1);
        for (int s = 0; s < stall; s++) begin
            check("r_hold_valid", rvalid, 1);
            check("r_hold_data", rdata, exp_base);
            step();
        end
        rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            check("r_valid", rvalid, 1);
            check("r_data", rdata, 8'(int'(exp_base) + i * int'(exp_step)));
            check("r_last", rlast, (i == int'(len)) ? 1 : 0);
            check("r_id", rid, id);
            check("r_resp", rresp, 0);
            step();
        end
        check("r_idle", rvalid, 0);
        $display("READ  addr=0x%04h len=%0d id=%0d burst=%0d stall=%0d", addr, len, id, burst, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_ids", {bid, rid}, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;
        step();
        check("idle_awready", awready, 1);
        check("idle_arready", arready, 1);

        // INCR write of 100 beats, data equal to beat index
        wr_burst(16'h0EEF, 8'd99, 8'd5, B_INCR, 8'd0);

        // Single-beat reads back
        rd_burst(16'h0EEF, 8'd0, 8'd5, B_INCR, 8'd0, 8'd0, 0);
        rd_burst(16'h0EF2, 8'd0, 8'd5, B_INCR, 8'd3, 8'd0, 0);
        rd_burst(16'h0EF5, 8'd0, 8'd5, B_INCR, 8'd6, 8'd0, 0);
        rd_burst(16'h0F52, 8'd0, 8'd5, B_INCR, 8'd99, 8'd0, 0);

        // Four-beat read with rready low for 5 cycles
        rd_burst(16'h0EEF, 8'd3, 8'd5, B_INCR, 8'd0, 8'd1, 5);

        // FIXED write lands every beat on one word; neighbour stays zero
        wr_burst(16'h0100, 8'd2, 8'd2, B_FIXED, 8'd7);
        rd_burst(16'h0100, 8'd2, 8'd2, B_FIXED, 8'd9, 8'd0, 0);
        rd_burst(16'h0101, 8'd0, 8'd2, B_INCR, 8'd0, 8'd0, 0);

        // B backpressure blocks the next AW
        bready = 1'b0;
        wr_burst(16'h0200, 8'd0, 8'd7, B_INCR, 8'h5A);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_bvalid", bvalid, 1);
            check("bp_awready", awready, 0);
        end
        bready = 1'b1;
        step();
        check("bp_b_taken", bvalid, 0);
        check("bp_awready_back", awready, 1);
        $display("BRESP backpressure released");
        rd_burst(16'h0200, 8'd0, 8'd7, B_INCR, 8'h5A, 8'd0, 0);

        // Reset in the middle of an 8-beat read
        araddr = 16'h0EEF; arlen = 8'd7; arid = 8'd3; arburst = B_INCR; arvalid = 1'b1;
        rready = 1'b1;
        for (int k = 0; k < 20 && !arready; k++) step();
        check("mid_ar_ready", arready, 1);
        step();
        arvalid = 1'b0;
        step();
        check("mid_rvalid", rvalid, 1);
        check("mid_rdata", rdata, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_arready", arready, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_arready", arready, 1);
        $display("RESET mid read burst");
        rd_burst(16'h0EF5, 8'd0, 8'd9, B_INCR, 8'd6, 8'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
